// File: rtl/neuron_layer_pkg.sv
// neuron_layer_pkg: shared definitions for the neuron layer sequencer.
//   - State encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3) and the typed FSM enum.
//   - requant(): ReLU + arithmetic right shift + unsigned saturation, with the
//     accumulator width, output width and shift passed in as arguments.
package neuron_layer_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StIssue = ISSUE,
        StWait  = WAIT,
        StDone  = DONE
    } state_e;

    // raw holds a width_acc-bit two's complement value in its low bits; the
    // upper bits are ignored. Result is zero-extended to 64 bits.
    function automatic logic [63:0] requant(input logic [63:0] raw,
                                            input int unsigned width_acc,
                                            input int unsigned width_out,
                                            input int unsigned shift);
        logic signed [63:0] acc;
        logic signed [63:0] t;
        logic [63:0]        max_val;
        logic [63:0]        res;
        // Sign-extend from width_acc to 64 bits.
        acc     = $signed(raw << (64 - width_acc)) >>> (64 - width_acc);
        t       = acc >>> shift;
        max_val = (64'd1 << width_out) - 64'd1;
        if (acc < 64'sd0) begin
            res = '0;
        end else if ($unsigned(t) > max_val) begin
            res = max_val;
        end else begin
            res = $unsigned(t);
        end
        return res;
    endfunction

endpackage

// File: rtl/neuron_layer_sequencer_requant.sv
// neuron_requant: combinational ReLU / shift / saturate stage.
// Ports:
//   acc  in   WIDTH_ACC  signed accumulator value (two's complement)
//   act  out  WIDTH_OUT  requantized unsigned activation
module neuron_requant
    import neuron_layer_pkg::*;
#(
    parameter int unsigned WIDTH_ACC = 32,
    parameter int unsigned WIDTH_OUT = 8,
    parameter int unsigned SHIFT     = 7
) (
    input  logic [WIDTH_ACC-1:0] acc,
    output logic [WIDTH_OUT-1:0] act
);

    always_comb begin
        act = WIDTH_OUT'(requant(64'(acc), WIDTH_ACC, WIDTH_OUT, SHIFT));
    end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: issues one shared neuron per output index, waits for
// its done strobe, requantizes the result and stores it in a flattened vector.
// Optional macro ARGMAX_EN adds a running argmax over the stored activations.
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   layer_go       in   start pulse, accepted only in IDLE
//   neuron_go      out  one-cycle start pulse to the neuron
//   neuron_sel     out  index of the active neuron
//   neuron_done    in   one-cycle completion strobe from the neuron
//   neuron_result  in   signed neuron output, valid with neuron_done
//   layer_out      out  activations; slot i at [(i+1)*WIDTH_OUT-1 -: WIDTH_OUT]
//   busy           out  pass in progress
//   layer_done     out  one-cycle pulse when all results are stored
//   argmax_idx     out  (ARGMAX_EN) lowest index holding the maximum activation
//   argmax_valid   out  (ARGMAX_EN) argmax_idx final for the completed pass
module neuron_layer_sequencer
    import neuron_layer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned WIDTH_ACC   = 32,
    parameter int unsigned WIDTH_OUT   = 8,
    parameter int unsigned SHIFT       = 7,
    localparam int unsigned SEL_W      = $clog2(NUM_NEURONS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             layer_go,
    output logic                             neuron_go,
    output logic [SEL_W-1:0]                 neuron_sel,
    input  logic                             neuron_done,
    input  logic [WIDTH_ACC-1:0]             neuron_result,
`ifdef ARGMAX_EN
    output logic [SEL_W-1:0]                 argmax_idx,
    output logic                             argmax_valid,
`endif
    output logic [WIDTH_OUT*NUM_NEURONS-1:0] layer_out,
    output logic                             busy,
    output logic                             layer_done
);

    state_e                           state_q, state_d;
    logic [SEL_W-1:0]                 sel_q, sel_d;
    logic [WIDTH_OUT*NUM_NEURONS-1:0] out_q, out_d;
    logic [WIDTH_OUT-1:0]             act;
    logic                             last;

    neuron_requant #(
        .WIDTH_ACC (WIDTH_ACC),
        .WIDTH_OUT (WIDTH_OUT),
        .SHIFT     (SHIFT)
    ) u_requant (
        .acc (neuron_result),
        .act (act)
    );

    assign last = (sel_q == SEL_W'(NUM_NEURONS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (layer_go) begin
                    state_d = StIssue;
                    sel_d   = '0;
                    out_d   = '0;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (neuron_done) begin
                    out_d[sel_q*WIDTH_OUT +: WIDTH_OUT] = act;
                    if (last) begin
                        state_d = StDone;
                    end else begin
                        sel_d   = sel_q + 1'b1;
                        state_d = StIssue;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign neuron_go  = (state_q == StIssue);
    assign busy       = (state_q != StIdle);
    assign layer_done = (state_q == StDone);
    assign neuron_sel = sel_q;
    assign layer_out  = out_q;

`ifdef ARGMAX_EN
    logic [WIDTH_OUT-1:0] max_q;
    logic [SEL_W-1:0]     idx_q;
    logic                 valid_q;

    // Strict compare keeps the lowest index on ties; valid rises on the edge
    // that enters DONE so it lines up with layer_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (state_q == StIdle && layer_go) begin
            max_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (state_q == StWait && neuron_done) begin
            if (act > max_q) begin
                max_q <= act;
                idx_q <= sel_q;
            end
            if (last) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign argmax_idx   = idx_q;
    assign argmax_valid = valid_q;
`endif

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
module tb_neuron_layer_sequencer;

    localparam int N = 10;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          layer_go;
    logic          neuron_go;
    logic [3:0]    neuron_sel;
    logic          neuron_done;
    logic [31:0]   neuron_result;
    logic [N*W-1:0] layer_out;
    logic          busy;
    logic          layer_done;
`ifdef ARGMAX_EN
    logic [3:0]    argmax_idx;
    logic          argmax_valid;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] res_tab [N];
    logic [W-1:0] exp_tab [N];

    neuron_layer_sequencer #(
        .NUM_NEURONS (N),
        .WIDTH_ACC   (32),
        .WIDTH_OUT   (W),
        .SHIFT       (7)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .layer_go      (layer_go),
        .neuron_go     (neuron_go),
        .neuron_sel    (neuron_sel),
        .neuron_done   (neuron_done),
        .neuron_result (neuron_result),
`ifdef ARGMAX_EN
        .argmax_idx    (argmax_idx),
        .argmax_valid  (argmax_valid),
`endif
        .layer_out     (layer_out),
        .busy          (busy),
        .layer_done    (layer_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] packed_exp();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = exp_tab[i];
        return r;
    endfunction

    // Pulse layer_go for one cycle; returns at the negedge where ISSUE is visible.
    task automatic start_pass();
        @(negedge clk);
        layer_go = 1'b1;
        @(negedge clk);
        layer_go = 1'b0;
    endtask

    task automatic wait_go(input int exp_sel);
        int n = 0;
        while (neuron_go !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("neuron_go_seen", neuron_go, 1);
        check("neuron_sel", neuron_sel, exp_sel);
        check("busy_in_pass", busy, 1);
`ifdef ARGMAX_EN
        check("argmax_valid_in_pass", argmax_valid, 0);
`endif
    endtask

    // Neuron model: done strobe d cycles after the go cycle.
    task automatic answer(input int d, input logic [31:0] res);
        @(negedge clk);
        check("neuron_go_one_cycle", neuron_go, 0);
        repeat (d - 1) @(negedge clk);
        neuron_done   = 1'b1;
        neuron_result = res;
        @(negedge clk);
        neuron_done   = 1'b0;
        neuron_result = 32'hDEAD_BEEF;
    endtask

    task automatic finish_checks(input int exp_idx);
        check("layer_done_pulse", layer_done, 1);
        check("layer_out_final", layer_out, packed_exp());
`ifdef ARGMAX_EN
        check("argmax_valid_with_done", argmax_valid, 1);
        check("argmax_idx", argmax_idx, exp_idx);
`endif
        // layer_go in the DONE cycle must be ignored.
        layer_go = 1'b1;
        @(negedge clk);
        layer_go = 1'b0;
        check("layer_done_one_cycle", layer_done, 0);
        check("busy_after_done", busy, 0);
        @(negedge clk);
        check("no_restart_go", neuron_go, 0);
        check("idle_busy", busy, 0);
        check("layer_out_held", layer_out, packed_exp());
        check("sel_held", neuron_sel, N - 1);
`ifdef ARGMAX_EN
        check("argmax_valid_held", argmax_valid, 1);
        check("argmax_idx_held", argmax_idx, exp_idx);
`endif
    endtask

    initial begin
        reset_n       = 1'b0;
        layer_go      = 1'b0;
        neuron_done   = 1'b0;
        neuron_result = '0;
        repeat (2) @(negedge clk);
        check("rst_neuron_go", neuron_go, 0);
        check("rst_neuron_sel", neuron_sel, 0);
        check("rst_layer_out", layer_out, 0);
        check("rst_busy", busy, 0);
        check("rst_layer_done", layer_done, 0);
`ifdef ARGMAX_EN
        check("rst_argmax_idx", argmax_idx, 0);
        check("rst_argmax_valid", argmax_valid, 0);
`endif
        reset_n = 1'b1;

        // Pass 1: done 3 cycles after each go; ReLU / shift / saturate cases.
        res_tab = '{32'hFFFF_FFFB, 32'd0, 32'd127, 32'd128000, 32'd256,
                    32'd1280, 32'd640, 32'd32767, 32'hFFFF_FFFF, 32'd12800};
        exp_tab = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd2, 8'd10, 8'd5, 8'd255, 8'd0, 8'd100};
        start_pass();
        for (int i = 0; i < N; i++) begin
            wait_go(i);
            answer(3, res_tab[i]);
        end
        finish_checks(3);

        // Stray done while idle captures nothing.
        neuron_done   = 1'b1;
        neuron_result = 32'd25600;
        @(negedge clk);
        neuron_done   = 1'b0;
        @(negedge clk);
        check("idle_done_ignored", layer_out, packed_exp());

        // Pass 2: spurious done in ISSUE, layer_go in WAIT; values {3,9,9,1,...}.
        res_tab = '{32'd484, 32'd1252, 32'd1252, 32'd228, 32'd100,
                    32'd740, 32'd356, 32'd996, 32'd1252, 32'd612};
        exp_tab = '{8'd3, 8'd9, 8'd9, 8'd1, 8'd0, 8'd5, 8'd2, 8'd7, 8'd9, 8'd4};
        start_pass();
        wait_go(0);
        neuron_done   = 1'b1;
        neuron_result = 32'd25600;
        @(negedge clk);
        neuron_done   = 1'b0;
        layer_go      = 1'b1;
        @(negedge clk);
        layer_go      = 1'b0;
        check("spurious_no_go", neuron_go, 0);
        check("spurious_sel", neuron_sel, 0);
        check("cleared_on_go", layer_out, 0);
        check("busy_wait", busy, 1);
        answer(1, res_tab[0]);
        for (int i = 1; i < N; i++) begin
            wait_go(i);
            answer(2, res_tab[i]);
        end
        finish_checks(1);

        // Pass 3: reset in WAIT at index 4.
        start_pass();
        for (int i = 0; i < 4; i++) begin
            wait_go(i);
            answer(2, 32'((i + 1) * 256));
        end
        wait_go(4);
        @(negedge clk);
        check("partial_layer_out", layer_out, 80'h0806_0402);
        reset_n       = 1'b0;
        neuron_done   = 1'b1;
        neuron_result = 32'd1280;
        #1;
        check("midrst_neuron_go", neuron_go, 0);
        check("midrst_sel", neuron_sel, 0);
        check("midrst_layer_out", layer_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_layer_done", layer_done, 0);
        @(negedge clk);
        reset_n     = 1'b1;
        neuron_done = 1'b0;
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        check("post_rst_out", layer_out, 0);

        // Pass 4: done in the cycle right after go, back-to-back.
        for (int i = 0; i < N; i++) begin
            res_tab[i] = 32'(i * 256);
            exp_tab[i] = W'(2 * i);
        end
        start_pass();
        for (int i = 0; i < N; i++) begin
            wait_go(i);
            answer(1, res_tab[i]);
        end
        finish_checks(9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_layer_sequencer.md
Name: neuron_layer_sequencer

Overview:
Initiator side of the neuron go/done handshake. On layer_go it starts one shared neuron instance per output index, one index at a time. For each index it waits for neuron_done, captures the accumulator result, applies ReLU plus requantization, and stores the byte in a flattened output register that feeds the next layer's in_data. It sits between the top-level inference controller and the neuron datapath.

Parameters:
NUM_NEURONS, 10, number of neurons evaluated per layer pass (>=2)
WIDTH_ACC, 32, width of the neuron result bus (signed)
WIDTH_OUT, 8, width of each stored activation (unsigned)
SHIFT, 7, arithmetic right shift applied before saturation (0..WIDTH_ACC-1)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
layer_go  in  1  start pulse; sampled only in IDLE
neuron_go  out  1  one-cycle start pulse to the neuron
neuron_sel  out  $clog2(NUM_NEURONS)  index of the active neuron; selects weight row and bias upstream
neuron_done  in  1  one-cycle completion strobe from the neuron
neuron_result  in  WIDTH_ACC  signed neuron output; valid only while neuron_done=1
layer_out  out  WIDTH_OUT*NUM_NEURONS  flattened activations; index i occupies [(i+1)*WIDTH_OUT-1 -: WIDTH_OUT]
busy  out  1  high from the accepted layer_go until layer_done
layer_done  out  1  one-cycle pulse when all NUM_NEURONS results are stored

Behaviour:
- Reset (asynchronous, reset_n=0) clears: state=IDLE, neuron_go=0, neuron_sel=0, layer_out=0, busy=0, layer_done=0.
- FSM states:
  - IDLE: on layer_go=1, go to ISSUE with neuron_sel=0; all layer_out entries cleared in the same cycle.
  - ISSUE: neuron_go=1 for exactly this one cycle; next state WAIT.
  - WAIT: hold until neuron_done=1. In that cycle, register requant(neuron_result) into slot neuron_sel.
    - If neuron_sel==NUM_NEURONS-1, go to DONE.
    - Otherwise increment neuron_sel and go to ISSUE.
  - DONE: layer_done=1 for one cycle; next state IDLE.
- Registered outputs: neuron_go, busy and layer_done are decoded from registered state only; no input-to-output combinational path.
- neuron_sel holds stable from ISSUE through the done cycle. It keeps its last value in DONE and IDLE until the next accepted layer_go.
- Requant rule:
  - ReLU: a negative neuron_result gives 0.
  - Otherwise compute t = neuron_result >>> SHIFT, then saturate to 2^WIDTH_OUT-1.
- Per-neuron latency: 1 ISSUE cycle plus the neuron's latency until done. Total pass time = sum over neurons + 1 DONE cycle + 1 initial IDLE->ISSUE cycle.
- Boundary cases:
  - layer_go while busy: ignored.
  - layer_go in the same cycle as DONE: ignored; a new pass needs layer_go in IDLE.
  - neuron_done outside WAIT: ignored, nothing captured.
  - Reset mid-pass: immediate return to IDLE with all outputs cleared. Any in-flight neuron result is discarded.
- layer_out holds its values after DONE until the next accepted layer_go.

Optional Feature:
ARGMAX_EN:
- Defined: adds output ports argmax_idx ($clog2(NUM_NEURONS)) and argmax_valid (1).
  - A running maximum of the requantized values is tracked, with a strict greater-than compare so the lowest index wins ties.
  - Both are cleared on accepted layer_go.
  - argmax_valid rises together with layer_done and stays high until the next accepted layer_go or reset.
  - Reset values are 0.
- Undefined: the ports, comparator and registers are absent. No other behaviour changes.

Decomposition:
- Package neuron_layer_pkg holds:
  - the state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - a requant function parameterised by WIDTH_ACC, WIDTH_OUT and SHIFT.
- One natural sub-module: neuron_requant, the combinational ReLU/shift/saturate stage. It is instantiated once and reused by the ARGMAX compare.

Test Plan:
- Reset, then layer_go, with a neuron model answering done 3 cycles after each go and NUM_NEURONS=10 -> 10 neuron_go pulses with neuron_sel=0..9 in order, one layer_done, busy high throughout.
- Results -5, 0, 127, 128*1000, 256 with SHIFT=7 -> stored 0, 0, 0, 255 (saturated), 2.
- layer_go pulsed during WAIT, plus a spurious neuron_done during ISSUE -> no restart, no extra capture, sequence count unchanged.
- reset_n asserted low mid-WAIT at neuron_sel=4 -> outputs zero immediately; the next layer_go restarts at neuron_sel=0.
- Neuron answering done in the cycle right after go, back-to-back -> every index captured, no skipped or duplicated slots.
- ARGMAX_EN with requantized values {3,9,9,1,...} -> argmax_idx=1, argmax_valid rises with layer_done.
